// File: rtl/spi_sensor_slave.sv
// rtl/spi_sensor_slave.sv - SPI slave streaming zero-padded sensor samples, MSB first
module spi_sensor_slave #(
    parameter int DATA_W      = 8,
    parameter int LEAD_ZEROS  = 4,
    parameter int TRAIL_ZEROS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ss,
    input  logic              sclk,
    output logic              miso,
    input  logic [DATA_W-1:0] sample_data,
    input  logic              sample_valid,
    output logic              sample_ready,
    output logic              frame_done,
    output logic              frame_abort,
    output logic [7:0]        frame_count
);
    localparam int FRAME_BITS = LEAD_ZEROS + DATA_W + TRAIL_ZEROS;
    localparam int CNT_W      = $clog2(FRAME_BITS + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, WAIT_SS} state_t;

    state_t                  state_q, state_d;
    logic                    ss_meta_q, ss_sync_q, ss_dly_q;
    logic                    sclk_meta_q, sclk_sync_q, sclk_dly_q;
    logic [FRAME_BITS-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0]       hold_q, hold_d;
    logic                    miso_q, miso_d;
    logic                    done_q, done_d;
    logic                    abort_q, abort_d;
    logic [7:0]              count_q, count_d;

    logic                    ss_fall, ss_rise, sclk_rise, sclk_fall;
    logic [FRAME_BITS-1:0]   frame_w;
    logic [CNT_W-1:0]        cnt_inc;

    // sclk strobes are qualified by the synchronized select so edges outside a frame never count
    assign ss_fall   =  ss_dly_q & ~ss_sync_q;
    assign ss_rise   = ~ss_dly_q &  ss_sync_q;
    assign sclk_rise = ~sclk_dly_q &  sclk_sync_q & ~ss_sync_q;
    assign sclk_fall =  sclk_dly_q & ~sclk_sync_q & ~ss_sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ss_meta_q   <= 1'b1;
            ss_sync_q   <= 1'b1;
            ss_dly_q    <= 1'b1;
            sclk_meta_q <= 1'b1;
            sclk_sync_q <= 1'b1;
            sclk_dly_q  <= 1'b1;
            state_q     <= IDLE;
            shift_q     <= '0;
            cnt_q       <= '0;
            hold_q      <= '0;
            miso_q      <= 1'b0;
            done_q      <= 1'b0;
            abort_q     <= 1'b0;
            count_q     <= '0;
        end else begin
            ss_meta_q   <= ss;
            ss_sync_q   <= ss_meta_q;
            ss_dly_q    <= ss_sync_q;
            sclk_meta_q <= sclk;
            sclk_sync_q <= sclk_meta_q;
            sclk_dly_q  <= sclk_sync_q;
            state_q     <= state_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            miso_q      <= miso_d;
            done_q      <= done_d;
            abort_q     <= abort_d;
            count_q     <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        miso_d  = miso_q;
        done_d  = 1'b0;
        abort_d = 1'b0;
        count_d = count_q;
        frame_w = '0;
        frame_w[TRAIL_ZEROS +: DATA_W] = hold_q;
        cnt_inc = cnt_q + 1'b1;

        if (sample_valid && state_q != SHIFT) begin
            hold_d = sample_data;
        end

        case (state_q)
            IDLE: begin
                miso_d = 1'b0;
                if (ss_fall) begin
                    shift_d = frame_w;
                    cnt_d   = '0;
                    miso_d  = frame_w[FRAME_BITS-1];
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (ss_rise) begin
                    abort_d = 1'b1;
                    miso_d  = 1'b0;
                    state_d = IDLE;
                end else if (sclk_fall) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_W'(FRAME_BITS)) begin
                        done_d  = 1'b1;
                        count_d = count_q + 8'd1;
                        miso_d  = 1'b0;
                        state_d = WAIT_SS;
                    end
                end else if (sclk_rise && cnt_q != '0) begin
                    // the rise before the first fall belongs to the idle-high clock, not a data bit
                    shift_d = {shift_q[FRAME_BITS-2:0], 1'b0};
                    miso_d  = shift_q[FRAME_BITS-2];
                end
            end
            WAIT_SS: begin
                miso_d = 1'b0;
                if (ss_rise) begin
                    state_d = IDLE;
                end
            end
            default: begin
                miso_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign miso         = miso_q;
    assign sample_ready = (state_q != SHIFT);
    assign frame_done   = done_q;
    assign frame_abort  = abort_q;
    assign frame_count  = count_q;
endmodule

// File: tb/tb_spi_sensor_slave.sv
// tb/tb_spi_sensor_slave.sv - scoreboard bench for spi_sensor_slave
module tb_spi_sensor_slave;
    logic       clk;
    logic       rst;
    logic       ss;
    logic       sclk;
    logic       miso;
    logic [7:0] sample_data;
    logic       sample_valid;
    logic       sample_ready;
    logic       frame_done;
    logic       frame_abort;
    logic [7:0] frame_count;

    int          total = 0;
    int          bad   = 0;
    int          done_seen  = 0;
    int          abort_seen = 0;
    int          nbits = 0;
    logic [15:0] cap = '0;
    logic [15:0] last_cap = '0;
    logic [15:0] sb[$];
    logic [7:0]  model_hold  = '0;
    logic [7:0]  model_count = '0;

    spi_sensor_slave #(.DATA_W(8), .LEAD_ZEROS(4), .TRAIL_ZEROS(4)) dut (
        .clk(clk), .rst(rst), .ss(ss), .sclk(sclk), .miso(miso),
        .sample_data(sample_data), .sample_valid(sample_valid), .sample_ready(sample_ready),
        .frame_done(frame_done), .frame_abort(frame_abort), .frame_count(frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done === 1'b1)  done_seen  = done_seen + 1;
        if (frame_abort === 1'b1) abort_seen = abort_seen + 1;
    end

    always @(negedge ss) nbits = 0;

    // Master capture: sample miso on each falling sclk, score every complete 16-bit frame
    always @(negedge sclk) begin
        logic [15:0] e;
        if (ss === 1'b0) begin
            cap   = {cap[14:0], miso};
            nbits = nbits + 1;
            if (nbits == 16) begin
                last_cap = cap;
                total = total + 1;
                if (sb.size() == 0) begin
                    bad = bad + 1;
                    $display("FAIL frame_unexpected got=%h", cap);
                end else begin
                    e = sb.pop_front();
                    if (cap !== e) begin
                        bad = bad + 1;
                        $display("FAIL frame_data got=%h exp=%h", cap, e);
                    end
                end
            end
        end
    end

    function automatic logic [15:0] exp_frame(input logic [7:0] h);
        return {4'b0000, h, 4'b0000};
    endfunction

    task automatic offer(input logic [7:0] d);
        sample_data  = d;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic start_frame(input logic [15:0] e, input bit push);
        if (push) sb.push_back(e);
        ss = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic clock_bits(input int n);
        for (int i = 0; i < n; i++) begin
            sclk = 1'b0;
            repeat (4) @(negedge clk);
            sclk = 1'b1;
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic end_frame();
        ss = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic full_frame();
        start_frame(exp_frame(model_hold), 1'b1);
        clock_bits(16);
        end_frame();
        model_count = model_count + 8'd1;
    endtask

    task automatic test_reset();
        total = total + 5;
        if (miso !== 1'b0)         begin bad++; $display("FAIL reset_miso got=%b exp=0", miso); end
        if (sample_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", sample_ready); end
        if (frame_done !== 1'b0)   begin bad++; $display("FAIL reset_done got=%b exp=0", frame_done); end
        if (frame_abort !== 1'b0)  begin bad++; $display("FAIL reset_abort got=%b exp=0", frame_abort); end
        if (frame_count !== 8'd0)  begin bad++; $display("FAIL reset_count got=%0d exp=0", frame_count); end
    endtask

    task automatic test_basic();
        int d0;
        offer(8'hA5);
        model_hold = 8'hA5;
        d0 = done_seen;
        full_frame();
        total = total + 3;
        if (done_seen !== d0 + 1)        begin bad++; $display("FAIL basic_done got=%0d exp=%0d", done_seen - d0, 1); end
        if (frame_count !== model_count) begin bad++; $display("FAIL basic_count got=%0d exp=%0d", frame_count, model_count); end
        if (last_cap[11:4] !== 8'hA5)    begin bad++; $display("FAIL basic_payload got=%h exp=a5", last_cap[11:4]); end
    endtask

    task automatic test_repeat();
        full_frame();
        full_frame();
        total = total + 1;
        if (frame_count !== model_count) begin bad++; $display("FAIL repeat_count got=%0d exp=%0d", frame_count, model_count); end
    endtask

    task automatic test_abort();
        int d0, a0;
        d0 = done_seen;
        a0 = abort_seen;
        start_frame(16'h0000, 1'b0);
        clock_bits(7);
        ss = 1'b1;
        repeat (8) @(negedge clk);
        total = total + 4;
        if (abort_seen !== a0 + 1)       begin bad++; $display("FAIL abort_pulse got=%0d exp=1", abort_seen - a0); end
        if (done_seen !== d0)            begin bad++; $display("FAIL abort_done got=%0d exp=0", done_seen - d0); end
        if (frame_count !== model_count) begin bad++; $display("FAIL abort_count got=%0d exp=%0d", frame_count, model_count); end
        if (miso !== 1'b0)               begin bad++; $display("FAIL abort_miso got=%b exp=0", miso); end
        full_frame();
        total = total + 1;
        if (frame_count !== model_count) begin bad++; $display("FAIL abort_next_count got=%0d exp=%0d", frame_count, model_count); end
    endtask

    task automatic test_busy_sample();
        start_frame(exp_frame(model_hold), 1'b1);
        clock_bits(5);
        sample_data  = 8'h3C;
        sample_valid = 1'b1;
        @(negedge clk);
        total = total + 1;
        if (sample_ready !== 1'b0) begin bad++; $display("FAIL busy_ready got=%b exp=0", sample_ready); end
        clock_bits(10);
        sample_valid = 1'b0;
        clock_bits(1);
        end_frame();
        model_count = model_count + 8'd1;
        total = total + 1;
        if (sample_ready !== 1'b1) begin bad++; $display("FAIL idle_ready got=%b exp=1", sample_ready); end
        offer(8'h3C);
        model_hold = 8'h3C;
        full_frame();
    endtask

    task automatic test_reset_mid();
        int a0;
        a0 = abort_seen;
        start_frame(16'h0000, 1'b0);
        clock_bits(9);
        rst = 1'b1;
        #1;
        test_reset();
        ss = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        model_hold  = 8'h00;
        model_count = 8'd0;
        total = total + 1;
        if (abort_seen !== a0) begin bad++; $display("FAIL rst_abort got=%0d exp=0", abort_seen - a0); end
        full_frame();
        total = total + 1;
        if (frame_count !== model_count) begin bad++; $display("FAIL rst_next_count got=%0d exp=%0d", frame_count, model_count); end
    endtask

    task automatic test_wrap();
        int d0;
        offer(8'h81);
        model_hold = 8'h81;
        while (model_count != 8'd255) full_frame();
        total = total + 1;
        if (frame_count !== 8'd255) begin bad++; $display("FAIL wrap_pre got=%0d exp=255", frame_count); end
        d0 = done_seen;
        full_frame();
        total = total + 2;
        if (frame_count !== 8'd0)  begin bad++; $display("FAIL wrap_count got=%0d exp=0", frame_count); end
        if (done_seen !== d0 + 1)  begin bad++; $display("FAIL wrap_done got=%0d exp=1", done_seen - d0); end
    endtask

    initial begin
        rst          = 1'b1;
        ss           = 1'b1;
        sclk         = 1'b1;
        sample_data  = '0;
        sample_valid = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        repeat (4) @(negedge clk);
        test_reset();
        test_basic();
        test_repeat();
        test_abort();
        test_busy_sample();
        test_reset_mid();
        test_wrap();
        total = total + 1;
        if (sb.size() != 0) begin bad++; $display("FAIL sb_leftover got=%0d exp=0", sb.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
